// File: rtl/cfg_discovery_regs.sv
// Discovery register table on AHB-Lite: read-only configuration words plus a
// runtime feature-enable register guarded by a set-only lock.
`timescale 1ns/1ps

package cfg_discovery_pkg;
  typedef struct packed {
    int          XLEN;
    int          AHBW;
    int          PA_BITS;
    logic [63:0] MISA;
    int          DCACHE_NUMWAYS;
    int          DCACHE_LINELENINBITS;
    int          DCACHE_WAYSIZEINBYTES;
    int          ICACHE_NUMWAYS;
    int          ICACHE_LINELENINBITS;
    int          ICACHE_WAYSIZEINBYTES;
    logic [63:0] RESET_VECTOR;
    logic [63:0] CLINT_BASE;
    logic [63:0] UART_BASE;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{XLEN: 64, AHBW: 64, PA_BITS: 56, MISA: 64'h8000_0000_0014_112D,
    DCACHE_NUMWAYS: 4, DCACHE_LINELENINBITS: 512, DCACHE_WAYSIZEINBYTES: 4096,
    ICACHE_NUMWAYS: 2, ICACHE_LINELENINBITS: 256, ICACHE_WAYSIZEINBYTES: 8192,
    RESET_VECTOR: 64'h8000_0000, CLINT_BASE: 64'h0200_0000, UART_BASE: 64'h1000_0000};

  localparam cvw_t CVW_RV32 = '{XLEN: 32, AHBW: 32, PA_BITS: 34, MISA: 64'h4014_112D,
    DCACHE_NUMWAYS: 4, DCACHE_LINELENINBITS: 512, DCACHE_WAYSIZEINBYTES: 4096,
    ICACHE_NUMWAYS: 2, ICACHE_LINELENINBITS: 256, ICACHE_WAYSIZEINBYTES: 8192,
    RESET_VECTOR: 64'h8000_0000, CLINT_BASE: 64'h0200_0000, UART_BASE: 64'h1000_0000};
endpackage

module cfg_discovery_regs
  import cfg_discovery_pkg::*;
#(
  parameter cvw_t                 P           = CVW_RV64,
  parameter int                   NUM_WORDS   = 16,
  parameter int                   WAIT_STATES = 0,
  parameter int                   FEAT_BITS   = 8,
  parameter logic [FEAT_BITS-1:0] FEAT_RESET  = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSELCfg,
  input  logic [P.PA_BITS-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic                 HREADY,
  input  logic [P.AHBW-1:0]    HWDATA,
  output logic [P.AHBW-1:0]    HRDATA,
  output logic                 HREADYCfg,
  output logic                 HRESPCfg,
  output logic [FEAT_BITS-1:0] FeatureEn
);
  localparam int             AW       = P.AHBW;
  localparam int             IDXW     = $clog2(NUM_WORDS);
  localparam logic [2:0]     SIZE_OK  = (AW == 64) ? 3'd3 : 3'd2;
  localparam logic [IDXW-1:0] IDX_FEAT = IDXW'(8);
  localparam logic [IDXW-1:0] IDX_LOCK = IDXW'(9);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                half_q, half_d;
  logic                wr_q, wr_d;
  logic [FEAT_BITS-1:0] feat_q, feat_d;
  logic                lock_q, lock_d;
  logic                hready_q, hready_d;
  logic                hresp_q, hresp_d;

  logic            accept, commit, is_err;
  logic [IDXW-1:0] a_idx;
  logic [63:0]     entry, rd_sel;

  always_comb begin
    a_idx  = HADDR[IDXW+2:3];
    accept = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2)
             & HSELCfg & HTRANS[1] & HREADY;
    // On a 32-bit bus the upper halves of FEATCTL/LOCK are write-ignored.
    commit = (state_q == S_DATA) && wr_q && !(AW == 32 && half_q);

    feat_d = feat_q;
    lock_d = lock_q;
    if (commit && idx_q == IDX_FEAT) feat_d = HWDATA[FEAT_BITS-1:0];
    if (commit && idx_q == IDX_LOCK) lock_d = lock_q | HWDATA[0];

    // lock_d lets a transfer accepted alongside a LOCK commit see the new lock.
    is_err = (HSIZE != SIZE_OK)
           | (HWRITE & (a_idx != IDX_FEAT) & (a_idx != IDX_LOCK))
           | (HWRITE & (a_idx == IDX_FEAT) & lock_d);

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    half_d  = half_q;
    wr_d    = wr_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      idx_d  = a_idx;
      half_d = HADDR[2];
      wr_d   = HWRITE;
      if (is_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES - 1);
      end else begin
        state_d = S_DATA;
      end
    end

    hready_d = !(state_d == S_WAIT || state_d == S_ERR1);
    hresp_d  = (state_d == S_ERR1 || state_d == S_ERR2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      half_q   <= 1'b0;
      wr_q     <= 1'b0;
      feat_q   <= FEAT_RESET;
      lock_q   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      half_q   <= half_d;
      wr_q     <= wr_d;
      feat_q   <= feat_d;
      lock_q   <= lock_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  always_comb begin
    entry = 64'h0;
    case (idx_q)
      IDXW'(0): entry = 64'h5741_4C4C_4346_4731;
      IDXW'(1): entry = P.MISA;
      IDXW'(2): entry = {16'(P.PA_BITS), 16'(P.AHBW), 16'(P.XLEN), 16'h0001};
      IDXW'(3): entry = {16'(P.DCACHE_NUMWAYS), 16'(P.DCACHE_LINELENINBITS),
                         32'(P.DCACHE_WAYSIZEINBYTES)};
      IDXW'(4): entry = {16'(P.ICACHE_NUMWAYS), 16'(P.ICACHE_LINELENINBITS),
                         32'(P.ICACHE_WAYSIZEINBYTES)};
      IDXW'(5): entry = P.RESET_VECTOR;
      IDXW'(6): entry = P.CLINT_BASE;
      IDXW'(7): entry = P.UART_BASE;
      IDX_FEAT: entry = 64'(feat_q);
      IDX_LOCK: entry = {63'h0, lock_q};
      default:  entry = 64'h0;
    endcase
    rd_sel = (AW == 32 && half_q) ? {32'h0, entry[63:32]} : entry;
    HRDATA = (state_q == S_DATA && !wr_q) ? rd_sel[AW-1:0] : '0;
  end

  assign HREADYCfg = hready_q;
  assign HRESPCfg  = hresp_q;
  assign FeatureEn = feat_q;

  logic unused_bits;
  assign unused_bits = ^{HADDR, HTRANS[0], HWDATA};
endmodule

// File: tb/tb_cfg_discovery_regs.sv
// Bench for cfg_discovery_regs: three instances (64-bit, 32-bit, 64-bit with
// three wait states) driven from a vector table plus pipelined corner sequences.
`timescale 1ns/1ps

module tb_cfg_discovery_regs;
  import cfg_discovery_pkg::*;

  localparam logic [63:0] MAGIC  = 64'h5741_4C4C_4346_4731;
  localparam logic [63:0] MISA64 = 64'h8000_0000_0014_112D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel   [3];
  logic [63:0] haddr  [3];
  logic [1:0]  htrans [3];
  logic        hwrite [3];
  logic [2:0]  hsize  [3];
  logic [63:0] hwdata [3];

  logic [63:0] rd0, rd2;
  logic [31:0] rd1;
  logic        rdy0, rdy1, rdy2, rsp0, rsp1, rsp2;
  logic [7:0]  fe0, fe1, fe2;

  logic [63:0] rd  [3];
  logic        rdy [3];
  logic        rsp [3];
  logic [7:0]  fe  [3];

  always_comb begin
    rd[0] = rd0; rd[1] = {32'h0, rd1}; rd[2] = rd2;
    rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2;
    rsp[0] = rsp0; rsp[1] = rsp1; rsp[2] = rsp2;
    fe[0] = fe0; fe[1] = fe1; fe[2] = fe2;
  end

  cfg_discovery_regs #(.P(CVW_RV64), .NUM_WORDS(16), .WAIT_STATES(0), .FEAT_BITS(8),
                       .FEAT_RESET(8'hFF)) u_dut64 (
    .clk(clk), .reset(rst), .HSELCfg(hsel[0]), .HADDR(haddr[0][55:0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HREADY(rdy0), .HWDATA(hwdata[0]),
    .HRDATA(rd0), .HREADYCfg(rdy0), .HRESPCfg(rsp0), .FeatureEn(fe0));

  cfg_discovery_regs #(.P(CVW_RV32), .NUM_WORDS(16), .WAIT_STATES(0), .FEAT_BITS(8),
                       .FEAT_RESET(8'hFF)) u_dut32 (
    .clk(clk), .reset(rst), .HSELCfg(hsel[1]), .HADDR(haddr[1][33:0]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HREADY(rdy1), .HWDATA(hwdata[1][31:0]),
    .HRDATA(rd1), .HREADYCfg(rdy1), .HRESPCfg(rsp1), .FeatureEn(fe1));

  cfg_discovery_regs #(.P(CVW_RV64), .NUM_WORDS(16), .WAIT_STATES(3), .FEAT_BITS(8),
                       .FEAT_RESET(8'hA5)) u_dutws (
    .clk(clk), .reset(rst), .HSELCfg(hsel[2]), .HADDR(haddr[2][55:0]), .HTRANS(htrans[2]),
    .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HREADY(rdy2), .HWDATA(hwdata[2]),
    .HRDATA(rd2), .HREADYCfg(rdy2), .HRESPCfg(rsp2), .FeatureEn(fe2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single transfer: address phase, then data phase until the slave is ready.
  task automatic xfer(input int d, input bit wr, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [2:0] size,
                      output logic [63:0] rdata, output int waits, output logic resp);
    @(posedge clk); #1;
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = addr; hsize[d] = size;
    @(posedge clk); #1;
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hwdata[d] = wdata;
    waits = 0; rdata = '0; resp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        rdata = rd[d];
        resp  = rsp[d];
        break;
      end
      waits++;
    end
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [63:0] exp_rd;
    int          exp_waits;
    bit          exp_err;
    logic [7:0]  exp_fe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int d, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [2:0] size,
                             input logic [63:0] exp_rd, input int exp_waits,
                             input bit exp_err, input logic [7:0] exp_fe);
    vec_t t;
    t.d = d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size;
    t.exp_rd = exp_rd; t.exp_waits = exp_waits; t.exp_err = exp_err; t.exp_fe = exp_fe;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rdata;
    int          waits;
    logic        resp;

    for (int i = 0; i < 3; i++) begin
      hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00; hwrite[i] = 1'b0;
      hsize[i] = 3'd3; hwdata[i] = '0;
    end

    // 64-bit, no wait states
    vecs.push_back(v(0, 0, 64'h00, 0, 3, MAGIC, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h08, 0, 3, MISA64, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h10, 0, 3, 64'h0038_0040_0040_0001, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h18, 0, 3, 64'h0004_0200_0000_1000, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h20, 0, 3, 64'h0002_0100_0000_2000, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h28, 0, 3, 64'h8000_0000, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h30, 0, 3, 64'h0200_0000, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h38, 0, 3, 64'h1000_0000, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h40, 0, 3, 64'hFF, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h48, 0, 3, 64'h0, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h50, 0, 3, 64'h0, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h7C, 0, 3, 64'h0, 0, 0, 8'hFF));
    vecs.push_back(v(0, 0, 64'h84, 0, 3, MAGIC, 0, 0, 8'hFF));
    vecs.push_back(v(0, 1, 64'h40, 64'h5A, 3, 64'h0, 0, 0, 8'h5A));
    vecs.push_back(v(0, 0, 64'h40, 0, 3, 64'h5A, 0, 0, 8'h5A));
    vecs.push_back(v(0, 1, 64'h48, 64'h1, 3, 64'h0, 0, 0, 8'h5A));
    vecs.push_back(v(0, 0, 64'h48, 0, 3, 64'h1, 0, 0, 8'h5A));
    vecs.push_back(v(0, 1, 64'h40, 64'h0, 3, 64'h0, 1, 1, 8'h5A));
    vecs.push_back(v(0, 1, 64'h48, 64'h0, 3, 64'h0, 0, 0, 8'h5A));
    vecs.push_back(v(0, 0, 64'h48, 0, 3, 64'h1, 0, 0, 8'h5A));
    vecs.push_back(v(0, 1, 64'h00, 64'h1234, 3, 64'h0, 1, 1, 8'h5A));
    vecs.push_back(v(0, 1, 64'h08, 64'h0, 3, 64'h0, 1, 1, 8'h5A));
    vecs.push_back(v(0, 0, 64'h00, 0, 1, 64'h0, 1, 1, 8'h5A));
    vecs.push_back(v(0, 0, 64'h00, 0, 3, MAGIC, 0, 0, 8'h5A));
    // 32-bit, no wait states
    vecs.push_back(v(1, 0, 64'h04, 0, 2, 64'h5741_4C4C, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 64'h00, 0, 2, 64'h4346_4731, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 64'h10, 0, 2, 64'h0020_0001, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 64'h14, 0, 2, 64'h0022_0020, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 64'h0C, 0, 2, 64'h0, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 64'h08, 0, 2, 64'h4014_112D, 0, 0, 8'hFF));
    vecs.push_back(v(1, 1, 64'h44, 64'h33, 2, 64'h0, 0, 0, 8'hFF));
    vecs.push_back(v(1, 1, 64'h40, 64'h33, 2, 64'h0, 0, 0, 8'h33));
    vecs.push_back(v(1, 0, 64'h40, 0, 2, 64'h33, 0, 0, 8'h33));
    vecs.push_back(v(1, 0, 64'h00, 0, 3, 64'h0, 1, 1, 8'h33));
    vecs.push_back(v(1, 1, 64'h40, 64'h77, 3, 64'h0, 1, 1, 8'h33));
    // 64-bit, three wait states
    vecs.push_back(v(2, 0, 64'h08, 0, 3, MISA64, 3, 0, 8'hA5));
    vecs.push_back(v(2, 1, 64'h40, 64'h0F, 3, 64'h0, 3, 0, 8'h0F));
    vecs.push_back(v(2, 0, 64'h40, 0, 3, 64'h0F, 3, 0, 8'h0F));
    vecs.push_back(v(2, 0, 64'h00, 0, 2, 64'h0, 1, 1, 8'h0F));
    vecs.push_back(v(2, 1, 64'h10, 64'h0, 3, 64'h0, 1, 1, 8'h0F));
    vecs.push_back(v(2, 0, 64'h00, 0, 3, MAGIC, 3, 0, 8'h0F));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", 64'(rdy0), 64'h1); chk("rst_rsp0", 64'(rsp0), 64'h0);
    chk("rst_rd0", rd0, 64'h0);        chk("rst_fe0", 64'(fe0), 64'hFF);
    chk("rst_rdy1", 64'(rdy1), 64'h1); chk("rst_fe1", 64'(fe1), 64'hFF);
    chk("rst_rdy2", 64'(rdy2), 64'h1); chk("rst_fe2", 64'(fe2), 64'hA5);
    rst = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rdata, waits, resp);
      chk($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_waits", i), 64'(waits), 64'(vecs[i].exp_waits));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_feat", i), 64'(fe[vecs[i].d]), 64'(vecs[i].exp_fe));
    end

    // Back-to-back 32-bit reads of both magic halves, no idle cycle between
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b0; hsize[1] = 3'd2; haddr[1] = 64'h04;
    @(posedge clk); #1;
    haddr[1] = 64'h00;
    @(negedge clk);
    chk("b2b_rdy_a", 64'(rdy1), 64'h1);
    chk("b2b_rd_a", 64'(rd1), 64'h5741_4C4C);
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    @(negedge clk);
    chk("b2b_rdy_b", 64'(rdy1), 64'h1);
    chk("b2b_rsp_b", 64'(rsp1), 64'h0);
    chk("b2b_rd_b", 64'(rd1), 64'h4346_4731);

    // LOCK write immediately followed by a FEATCTL write must see the new lock
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = 64'h48;
    @(posedge clk); #1;
    haddr[1] = 64'h40; hwdata[1] = 64'h1;
    @(negedge clk);
    chk("race_lock_rdy", 64'(rdy1), 64'h1);
    chk("race_lock_rsp", 64'(rsp1), 64'h0);
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwrite[1] = 1'b0; hwdata[1] = 64'h77;
    @(negedge clk);
    chk("race_err1_rdy", 64'(rdy1), 64'h0);
    chk("race_err1_rsp", 64'(rsp1), 64'h1);
    @(negedge clk);
    chk("race_err2_rdy", 64'(rdy1), 64'h1);
    chk("race_err2_rsp", 64'(rsp1), 64'h1);
    @(posedge clk); #1;
    chk("race_feat", 64'(fe1), 64'h33);
    xfer(1, 0, 64'h48, 0, 2, rdata, waits, resp);
    chk("race_lock_rd", rdata, 64'h1);

    // Reset asserted during a wait-state cycle
    @(posedge clk); #1;
    hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b0; hsize[2] = 3'd3; haddr[2] = 64'h08;
    @(posedge clk); #1;
    hsel[2] = 1'b0; htrans[2] = 2'b00;
    @(negedge clk);
    chk("mid_wait_rdy", 64'(rdy2), 64'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(rdy2), 64'h1);
    chk("mid_rst_rsp", 64'(rsp2), 64'h0);
    chk("mid_rst_rd", rd2, 64'h0);
    chk("mid_rst_fe2", 64'(fe2), 64'hA5);
    chk("mid_rst_fe0", 64'(fe0), 64'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("post_rst_rdy2", 64'(rdy2), 64'h1);
    xfer(0, 0, 64'h48, 0, 3, rdata, waits, resp);
    chk("post_rst_lock", rdata, 64'h0);
    xfer(0, 1, 64'h40, 64'h11, 3, rdata, waits, resp);
    chk("post_rst_wr_resp", 64'(resp), 64'h0);
    @(posedge clk); #1;
    chk("post_rst_feat", 64'(fe0), 64'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
